// File: rtl/code_loader_pkg.sv
// loader_pkg: shared widths and controller state encoding for code_loader.
// When CODE_LOADER_CHECKSUM_EN is defined, the checksum state ST_CHK is added.
// Exports: LEN_W, WORD_W, BYTES_PER_WORD, state_e.
package loader_pkg;

  localparam int unsigned LEN_W          = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef CODE_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_FLUSH,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/code_loader_if.sv
// code_loader_if: groups the byte-stream handshake and the memory write port.
//   master: byte source / memory side (drives IN_DATA, IN_VALID)
//   slave : loader side (drives IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA)
interface code_loader_if;
  import loader_pkg::*;

  logic [7:0]        IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic              MEM_WE;
  logic [WORD_W-1:0] MEM_ADDR;
  logic [WORD_W-1:0] MEM_WDATA;

  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/code_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes.
//   clk_i, rst_i   : clock, synchronous active-high clear
//   byte_i         : incoming byte, consumed when accept_i is high
//   last_o         : the next accepted byte completes the current word
//   word_valid_o   : one-cycle registered pulse after the 4th byte
//   word_o         : last completed word {b3,b2,b1,b0}, held between pulses
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        byte_i,
  input  logic              accept_i,
  output logic              last_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        idx_q, idx_d;
  logic [23:0]       bytes_q, bytes_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  always_comb begin
    idx_d   = idx_q;
    bytes_d = bytes_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (accept_i) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        word_d  = {byte_i, bytes_q};
        valid_d = 1'b1;
      end else begin
        // Shift down so b0 ends up in the least significant byte.
        bytes_d = {byte_i, bytes_q[23:8]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      bytes_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign last_o       = (idx_q == 2'd3);
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/code_loader.sv
// code_loader: boot-time loader. Receives LEN (2 bytes, LE) then 4*LEN bytes,
// writes packed words to OFFSET + 4*k, holds CORE_RST until the image is in.
// Optional CODE_LOADER_CHECKSUM_EN: a trailing mod-256 sum byte is verified.
//   CLK, RST  : clock, synchronous active-high reset
//   bus       : code_loader_if.slave (byte handshake + memory write port)
//   CORE_RST  : core reset, released after successful load
//   DONE      : sticky load-complete flag
//   ERROR     : sticky abort flag
module code_loader
  import loader_pkg::*;
#(
  parameter int unsigned       SIZE   = 1024,
  parameter logic [WORD_W-1:0] OFFSET = '0
) (
  input  logic        CLK,
  input  logic        RST,
  code_loader_if.slave bus,
  output logic        CORE_RST,
  output logic        DONE,
  output logic        ERROR
);

`ifdef CODE_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHK;
`else
  localparam state_e ST_AFTER_DATA = ST_FLUSH;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              done_q, err_q, core_rst_q;
  logic              ready;
  logic              accept;
  logic              word_last;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [LEN_W-1:0]  len_in;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_LEN0, ST_LEN1, ST_DATA: ready = 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
      ST_CHK:                    ready = 1'b1;
`endif
      default:                   ready = 1'b0;
    endcase
  end

  assign accept = bus.IN_VALID && ready;
  assign len_in = {bus.IN_DATA, len_q[7:0]};

  byte_packer u_packer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .byte_i       (bus.IN_DATA),
    .accept_i     (accept && (state_q == ST_DATA)),
    .last_o       (word_last),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
`ifdef CODE_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    if (accept && (state_q != ST_CHK)) sum_d = sum_q + bus.IN_DATA;
`endif
    case (state_q)
      ST_INIT: state_d = ST_LEN0;
      ST_LEN0: if (accept) begin
        len_d[7:0] = bus.IN_DATA;
        state_d    = ST_LEN1;
      end
      ST_LEN1: if (accept) begin
        len_d = len_in;
        if (32'(len_in) > SIZE)  state_d = ST_ERROR;
        else if (len_in == '0)   state_d = ST_AFTER_DATA;
        else                     state_d = ST_DATA;
      end
      ST_DATA: if (accept && word_last) begin
        // Address is registered alongside the packer's word so both appear
        // together in the cycle after the 4th byte.
        addr_d = OFFSET + 32'({cnt_q, 2'b00});
        cnt_d  = cnt_q + 16'd1;
        if (cnt_d == len_q) state_d = ST_AFTER_DATA;
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      ST_CHK: if (accept) begin
        state_d = (bus.IN_DATA == sum_q) ? ST_FLUSH : ST_ERROR;
      end
`endif
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= OFFSET;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      // Status flags lag the state register by one cycle, so DONE follows
      // FLUSH by two edges and the final write always precedes core release.
      done_q     <= (state_q == ST_DONE);
      err_q      <= (state_q == ST_ERROR);
      core_rst_q <= (state_q != ST_DONE);
`ifdef CODE_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.IN_READY  = ready;
  assign bus.MEM_WE    = word_valid;
  assign bus.MEM_ADDR  = addr_q;
  assign bus.MEM_WDATA = word;
  assign CORE_RST      = core_rst_q;
  assign DONE          = done_q;
  assign ERROR         = err_q;

endmodule

// File: tb/tb_code_loader.sv
module tb_code_loader;

  localparam int unsigned SIZE   = 1024;
  localparam logic [31:0] OFFSET = 32'h0000_0100;
  localparam int          INF    = 1 << 30;
`ifdef CODE_LOADER_CHECKSUM_EN
  localparam int          CHK    = 1;
`else
  localparam int          CHK    = 0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic core_rst, done, error;
  always #5 clk = ~clk;

  code_loader_if bus();

  code_loader #(.SIZE(SIZE), .OFFSET(OFFSET)) dut (
    .CLK      (clk),
    .RST      (rst),
    .bus      (bus),
    .CORE_RST (core_rst),
    .DONE     (done),
    .ERROR    (error)
  );

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  int errors = 0;
  int checks = 0;

  // Reference model state: edge numbers at which outputs take effect.
  int          ready_from  = INF;
  int          ready_until = INF;
  int          done_at     = INF;
  int          err_at      = INF;
  int          total       = INF;
  int          mlen        = 0;
  logic [7:0]  acc[$];
  wr_t         wq[$];
  int          writes_seen = 0;
  logic [31:0] last_addr   = '0;
  logic [31:0] last_data   = '0;
  bit          started     = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    ready_from  = INF;
    ready_until = INF;
    done_at     = INF;
    err_at      = INF;
    total       = INF;
    mlen        = 0;
    acc.delete();
    wq.delete();
    writes_seen = 0;
  endtask

  // A byte accepted at edge e.
  task automatic model_accept(input logic [7:0] b, input int e);
    int  n;
    int  i;
    bit  ok;
    logic [7:0] sum;
    wr_t w;
    acc.push_back(b);
    n = acc.size();
    if (n == 2) begin
      mlen = int'({acc[1], acc[0]});
      if (mlen > int'(SIZE)) begin
        err_at      = e + 1;
        ready_until = e;
        return;
      end
      total = 2 + 4 * mlen + CHK;
    end else if (n > 2 && n <= 2 + 4 * mlen) begin
      i = n - 3;
      if (i % 4 == 3) begin
        w.due  = e;
        w.addr = OFFSET + 32'(4 * (i / 4));
        w.data = {acc[n-1], acc[n-2], acc[n-3], acc[n-4]};
        wq.push_back(w);
      end
    end
    if (n == total) begin
      ok = 1'b1;
      if (CHK == 1) begin
        sum = '0;
        for (int k = 0; k < n - 1; k++) sum = sum + acc[k];
        ok = (b == sum);
      end
      ready_until = e;
      if (ok) done_at = e + 2;
      else    err_at  = e + 1;
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    bit exp_we;
    if (started) begin
      if (rst_at_edge) begin
        chk("rst_in_ready",  32'(bus.IN_READY), 32'd0);
        chk("rst_mem_we",    32'(bus.MEM_WE),   32'd0);
        chk("rst_mem_addr",  bus.MEM_ADDR,      OFFSET);
        chk("rst_mem_wdata", bus.MEM_WDATA,     32'd0);
        chk("rst_core_rst",  32'(core_rst),     32'd1);
        chk("rst_done",      32'(done),         32'd0);
        chk("rst_error",     32'(error),        32'd0);
      end else begin
        exp_we = (wq.size() > 0) && (wq[0].due == cyc);
        chk("mem_we", 32'(bus.MEM_WE), 32'(exp_we));
        if (exp_we) begin
          chk("mem_addr",  bus.MEM_ADDR,  wq[0].addr);
          chk("mem_wdata", bus.MEM_WDATA, wq[0].data);
          void'(wq.pop_front());
        end
        if (bus.MEM_WE) begin
          writes_seen++;
          last_addr = bus.MEM_ADDR;
          last_data = bus.MEM_WDATA;
        end
        chk("in_ready", 32'(bus.IN_READY), 32'(cyc >= ready_from && cyc < ready_until));
        chk("done",     32'(done),         32'(cyc >= done_at));
        chk("core_rst", 32'(core_rst),     32'(!(cyc >= done_at)));
        chk("error",    32'(error),        32'(cyc >= err_at));
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst          = 1'b1;
    bus.IN_VALID = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    started = 1'b1;
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    ready_from = cyc + 1;
  endtask

  task automatic send(input bq_t s, input int gap);
    int idx = 0;
    int budget = 4000;
    while (idx < s.size() && budget > 0) begin
      @(negedge clk);
      if ($urandom_range(99) >= gap) begin
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = s[idx];
      end else begin
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'($urandom);
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        model_accept(s[idx], cyc + 1);
        idx++;
      end
      budget--;
    end
    chk("send_complete", 32'(idx), 32'(s.size()));
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'($urandom);
  endtask

  function automatic bq_t make_stream(input int len);
    bq_t        s;
    logic [7:0] sum;
    s.push_back(len[7:0]);
    s.push_back(len[15:8]);
    for (int k = 0; k < 4 * len; k++) s.push_back(8'($urandom));
    if (CHK == 1) begin
      sum = '0;
      foreach (s[k]) sum = sum + s[k];
      s.push_back(sum);
    end
    return s;
  endfunction

  task automatic settle(input string name, input bit exp_done, input bit exp_err, input int exp_writes);
    repeat (6) @(posedge clk);
    #2;
    chk({name, "_done"},   32'(done),        32'(exp_done));
    chk({name, "_error"},  32'(error),       32'(exp_err));
    chk({name, "_writes"}, 32'(writes_seen), 32'(exp_writes));
  endtask

  initial begin
    bq_t s;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    do_reset(3);

    // Single word, no gaps.
    s = {8'h01, 8'h00, 8'h13, 8'h05, 8'hE0, 8'hFF};
    if (CHK == 1) s.push_back(8'hF8);
    send(s, 0);
    settle("len1", 1'b1, 1'b0, 1);
    chk("len1_addr", last_addr, 32'h0000_0100);
    chk("len1_data", last_data, 32'hFFE0_0513);

    // Three words with random valid gaps.
    do_reset(2);
    send(make_stream(3), 40);
    settle("len3", 1'b1, 1'b0, 3);
    chk("len3_last_addr", last_addr, 32'h0000_0108);

    // Empty image.
    do_reset(2);
    send(make_stream(0), 30);
    settle("len0", 1'b1, 1'b0, 0);

    // Oversized length.
    do_reset(2);
    s = {8'h01, 8'h04};
    send(s, 0);
    settle("oversize", 1'b0, 1'b1, 0);
    chk("oversize_core_rst", 32'(core_rst), 32'd1);

    // Reset in the middle of the first word, then a clean load.
    do_reset(2);
    s = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send(s, 20);
    do_reset(1);
    send(make_stream(1), 20);
    settle("midrst", 1'b1, 1'b0, 1);

`ifdef CODE_LOADER_CHECKSUM_EN
    // Bad checksum: word still written, core held in reset.
    do_reset(2);
    s = {8'h01, 8'h00, 8'h13, 8'h05, 8'hE0, 8'hFF, 8'hF7};
    send(s, 0);
    settle("badchk", 1'b0, 1'b1, 1);
    chk("badchk_data",     last_data,       32'hFFE0_0513);
    chk("badchk_core_rst", 32'(core_rst),   32'd1);
`endif

    // Back-to-back words at full rate.
    do_reset(2);
    send(make_stream(8), 0);
    settle("b2b", 1'b1, 1'b0, 8);
    chk("b2b_last_addr", last_addr, 32'h0000_011C);

    // Longer random-gap load.
    do_reset(2);
    send(make_stream(5), 50);
    settle("len5", 1'b1, 1'b0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_loader.md
# code_loader

Boot-time program loader: receives a byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words, and writes them sequentially into the core's instruction/data memory write port. It holds the processor (`Main`) in reset until the image is fully written, then releases it. It sits between the host/UART byte source and the memory write port, on the write side of the memory image that the bench later dumps word by word.

## Interface
- `SIZE`, 1024, memory capacity in 32-bit words; maximum loadable word count.
- `OFFSET`, 0, byte address of the first written word.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `IN_DATA`  in  8  stream byte.
- `IN_VALID`  in  1  `IN_DATA` valid.
- `IN_READY`  out  1  loader accepts a byte this cycle.
- `MEM_WE`  out  1  one-cycle word write strobe.
- `MEM_ADDR`  out  32  byte address of the write.
- `MEM_WDATA`  out  32  word to write.
- `CORE_RST`  out  1  reset to the core; high until load completes.
- `DONE`  out  1  load completed successfully; sticky.
- `ERROR`  out  1  load aborted; sticky.

## Operation
- Stream format: `LEN[7:0]`, `LEN[15:8]`, then `4*LEN` data bytes (per word: `b0..b3`, word = `{b3,b2,b1,b0}`). With `CODE_LOADER_CHECKSUM_EN`, one trailing checksum byte follows.
- Byte accepted on the edge where `IN_VALID && IN_READY`. `IN_DATA` is ignored otherwise.
- States: `INIT` → `LEN0` → `LEN1` → `DATA` → (`CHK`) → `FLUSH` → `DONE`; `ERROR` is reachable from `LEN1` and `CHK`.
- `INIT`: one cycle after reset, `IN_READY=0`; unconditional move to `LEN0`.
- `IN_READY` is decoded from the state register: 1 in `LEN0`, `LEN1`, `DATA`, `CHK`; 0 otherwise.
- `LEN1` accepted: if `LEN > SIZE`, go to `ERROR`. If `LEN == 0`, go to `CHK`/`FLUSH`. Otherwise go to `DATA`.
- `DATA`: a 2-bit byte index and a 16-bit word counter. The 4th byte of word k triggers a write of word k to `OFFSET + 4*k` (32-bit wrap). After word `LEN-1`, go to `CHK`/`FLUSH`.
- `FLUSH`: one cycle, then `DONE`.
- `DONE`: `DONE=1`, `CORE_RST=0`, `IN_READY=0`; absorbing until `RST`.
- `ERROR`: `ERROR=1`, `CORE_RST=1`, `IN_READY=0`, no further writes; absorbing until `RST`.
- Reset mid-load: state returns to `INIT`, and the partial word and counters are discarded. Memory already written is not erased. Any later stream restarts from `LEN0`.

## Timing
- Reset values: `IN_READY=0`, `MEM_WE=0`, `MEM_ADDR=OFFSET`, `MEM_WDATA=0`, `CORE_RST=1`, `DONE=0`, `ERROR=0`.
- Earliest byte acceptance: the second edge after `RST` falls.
- Write latency: 4th byte accepted at edge e → `MEM_WE=1` with `MEM_ADDR`/`MEM_WDATA` valid during cycle e..e+1 (registered, exactly one cycle).
- The loader never stalls in `DATA`: one byte per cycle sustained, with back-to-back words.
- Completion: let e be the acceptance edge of the final stream byte (last data byte, `LEN1` if `LEN=0`, or the checksum byte). `DONE` rises and `CORE_RST` falls at edge e+2. The final `MEM_WE` always precedes `CORE_RST` deassertion by at least one cycle.
- `ERROR` rises at edge e+1 after the offending byte.
- `RST` has priority over every event in the same cycle.

## Configuration
- `CODE_LOADER_CHECKSUM_EN` defined: `CHK` state present. The expected byte is the 8-bit modulo-256 sum of all bytes from `LEN0` through the last data byte. Match → `FLUSH`; mismatch → `ERROR`.
- Undefined: no `CHK` state or adder; after the final data byte (or `LEN=0`) go directly to `FLUSH`.

## Structure
- Shared package `loader_pkg`: state encoding constants, `LEN_W=16`, `WORD_W=32`, `BYTES_PER_WORD=4`.
- One sub-module, `byte_packer`:
  - Inputs: byte plus accept.
  - Behaviour: shift-assembles a little-endian word with a 2-bit index.
  - Outputs: `word_valid` pulse and word.
  - Cleared by `RST`.
- Controller FSM, counter, and address generation stay in `code_loader`.

## Test plan
- `LEN=1`, bytes `01 00 13 05 E0 FF` → one `MEM_WE`, `MEM_ADDR=0x0`, `MEM_WDATA=0xFFE00513`. `DONE=1` and `CORE_RST=0` at e+2.
- `LEN=3`, `OFFSET=0x100`, random `IN_VALID` gaps → exactly 3 writes at `0x100`, `0x104`, `0x108` in order with correct words; no spurious `MEM_WE`.
- `LEN=0` (`00 00`) → no `MEM_WE`; `DONE` at e+2.
- `SIZE=1024`, `LEN=1025` (`01 04`) → `ERROR=1` at e+1, `IN_READY=0`, `CORE_RST` stays 1, zero writes.
- `RST` pulsed after 2 bytes of the first word, then a valid `LEN=1` stream → no write from the aborted word; a single correct write, then `DONE`.
- `CODE_LOADER_CHECKSUM_EN` defined:
  - Stream from scenario 1 + `F8` → `DONE`.
  - Same stream + `F7` → `ERROR`; the word is still written, `CORE_RST` stays 1.
